regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 106 ++++++++++
 tb/tb_regfile_scoreboard.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// NUM_REGS x DATA_W register file (R0 reads zero) with write-to-read bypass,
// per-register busy bits for in-flight producers, and a sequenced bulk clear.
module regfile_scoreboard #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              regfile_write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_busy1,
  output logic              read_busy2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [ADDR_W-1:0]   ptr;
  logic                idle;
  logic                byp1;
  logic                byp2;

  assign idle       = (state == IDLE);
  assign clear_busy = (state == SWEEP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      busy       <= '0;
      clear_done <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          // Clear wins over any same-cycle write or reserve.
          if (clear_req) begin
            state <= SWEEP;
            ptr   <= ADDR_W'(1);
            busy  <= '0;
          end else begin
            if (regfile_write_enable && write_addr != '0) begin
              regs[write_addr] <= write_data;
              busy[write_addr] <= 1'b0;
            end
            // Placed after the write so a colliding new producer keeps busy set.
            if (reserve_en && reserve_addr != '0) busy[reserve_addr] <= 1'b1;
          end
        end
        SWEEP: begin
          regs[ptr] <= '0;
          ptr       <= ptr + ADDR_W'(1);
          if (ptr == LAST) begin
            state      <= IDLE;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign byp1 = idle && regfile_write_enable && (write_addr == read_addr1);
  assign byp2 = idle && regfile_write_enable && (write_addr == read_addr2);

  always_comb begin
    read_data1 = regs[read_addr1];
    read_busy1 = busy[read_addr1];
    if (read_addr1 == '0) begin
      read_data1 = '0;
      read_busy1 = 1'b0;
    end else if (byp1) begin
      read_data1 = write_data;
      read_busy1 = 1'b0;
    end
  end

  always_comb begin
    read_data2 = regs[read_addr2];
    read_busy2 = busy[read_addr2];
    if (read_addr2 == '0) begin
      read_data2 = '0;
      read_busy2 = 1'b0;
    end else if (byp2) begin
      read_data2 = write_data;
      read_busy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios on an 8x4 instance and
// randomized traffic on a 32x16 instance against an array-based model.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 8 x 4 instance
  logic       we, re, cr, b1, b2, cb, cd;
  logic [2:0] wa, ra, a1, a2;
  logic [3:0] wd, d1, d2;

  // 32 x 16 instance
  logic        w_we, w_re, w_cr, w_b1, w_b2, w_cb, w_cd;
  logic [4:0]  w_wa, w_ra, w_a1, w_a2;
  logic [15:0] w_wd, w_d1, w_d2;

  regfile_scoreboard #(.DATA_W(4), .NUM_REGS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .regfile_write_enable(we), .write_addr(wa), .write_data(wd),
    .reserve_en(re), .reserve_addr(ra),
    .read_addr1(a1), .read_addr2(a2),
    .read_data1(d1), .read_data2(d2),
    .read_busy1(b1), .read_busy2(b2),
    .clear_req(cr), .clear_busy(cb), .clear_done(cd)
  );

  regfile_scoreboard #(.DATA_W(16), .NUM_REGS(32)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .regfile_write_enable(w_we), .write_addr(w_wa), .write_data(w_wd),
    .reserve_en(w_re), .reserve_addr(w_ra),
    .read_addr1(w_a1), .read_addr2(w_a2),
    .read_data1(w_d1), .read_data2(w_d2),
    .read_busy1(w_b1), .read_busy2(w_b2),
    .clear_req(w_cr), .clear_busy(w_cb), .clear_done(w_cd)
  );

  task automatic idle_inputs();
    we = 1'b0; wa = 3'd0; wd = 4'd0; re = 1'b0; ra = 3'd0;
    a1 = 3'd0; a2 = 3'd0; cr = 1'b0;
    w_we = 1'b0; w_wa = 5'd0; w_wd = 16'd0; w_re = 1'b0; w_ra = 5'd0;
    w_a1 = 5'd0; w_a2 = 5'd0; w_cr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #12 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cb !== 1'b0 || cd !== 1'b0) begin failures++;
      $display("FAIL reset_state clear_busy=%b clear_done=%b required 0 0", cb, cd); end
    // Write and reserve R3 together: data stored, busy left set
    we = 1'b1; wa = 3'd3; wd = 4'hA; re = 1'b1; ra = 3'd3;
    @(negedge clk);
    idle_inputs(); a1 = 3'd3; #1;
    checks++; if (d1 !== 4'hA || b1 !== 1'b1) begin failures++;
      $display("FAIL reset_pre_write data=%h busy=%b required a 1", d1, b1); end
    cr = 1'b1;
    @(negedge clk);
    cr = 1'b0; #1;
    checks++; if (cb !== 1'b1 || d1 !== 4'hA || b1 !== 1'b0) begin failures++;
      $display("FAIL reset_sweep_start clear_busy=%b data=%h busy=%b required 1 a 0", cb, d1, b1); end
    #2 reset_n = 1'b0; #1;
    checks++; if (d1 !== 4'h0 || b1 !== 1'b0 || cb !== 1'b0 || cd !== 1'b0) begin failures++;
      $display("FAIL reset_async data=%h busy=%b clear_busy=%b clear_done=%b required 0 0 0 0",
               d1, b1, cb, cd); end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_inputs(); we = 1'b1; wa = 3'd5; wd = 4'h7; a1 = 3'd5; #1;
    checks++; if (d1 !== 4'h7 || b1 !== 1'b0) begin failures++;
      $display("FAIL bypass_r5 data=%h busy=%b required 7 0", d1, b1); end
    @(negedge clk);
    we = 1'b1; wa = 3'd0; wd = 4'hF; a2 = 3'd0; #1;
    checks++; if (d2 !== 4'h0 || b2 !== 1'b0) begin failures++;
      $display("FAIL bypass_r0_now data=%h busy=%b required 0 0", d2, b2); end
    @(negedge clk);
    we = 1'b0; #1;
    checks++; if (d2 !== 4'h0 || d1 !== 4'h7) begin failures++;
      $display("FAIL bypass_after r0=%h r5=%h required 0 7", d2, d1); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle_inputs(); re = 1'b1; ra = 3'd2; a1 = 3'd2; #1;
    checks++; if (b1 !== 1'b0) begin failures++;
      $display("FAIL reserve_not_forwarded busy=%b required 0", b1); end
    @(negedge clk);
    re = 1'b0; #1;
    checks++; if (b1 !== 1'b1) begin failures++;
      $display("FAIL reserve_visible busy=%b required 1", b1); end
    @(negedge clk);
    we = 1'b1; wa = 3'd2; wd = 4'h3; #1;
    checks++; if (d1 !== 4'h3 || b1 !== 1'b0) begin failures++;
      $display("FAIL write_bypass_busy data=%h busy=%b required 3 0", d1, b1); end
    @(negedge clk);
    we = 1'b0; #1;
    checks++; if (d1 !== 4'h3 || b1 !== 1'b0) begin failures++;
      $display("FAIL write_clears_busy data=%h busy=%b required 3 0", d1, b1); end
    @(negedge clk);
    we = 1'b1; wa = 3'd4; wd = 4'h9; re = 1'b1; ra = 3'd4;
    @(negedge clk);
    idle_inputs(); a2 = 3'd4; #1;
    checks++; if (d2 !== 4'h9 || b2 !== 1'b1) begin failures++;
      $display("FAIL reserve_write_same data=%h busy=%b required 9 1", d2, b2); end
  endtask

  task automatic test_bulk_clear();
    logic exp_cb, exp_cd;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      idle_inputs(); we = 1'b1; wa = 3'(i); wd = 4'(i + 8);
      if (i == 6) begin re = 1'b1; ra = 3'd6; end
    end
    @(negedge clk);
    idle_inputs(); cr = 1'b1;
    @(negedge clk);
    cr = 1'b0; a1 = 3'd7; a2 = 3'd1;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      exp_cb = (k <= 7);
      exp_cd = (k == 8);
      checks++; if (cb !== exp_cb || cd !== exp_cd) begin failures++;
        $display("FAIL clear_timing cycle=%0d clear_busy=%b clear_done=%b required %b %b",
                 k, cb, cd, exp_cb, exp_cd); end
      // Writes while sweeping must be dropped and not bypassed
      we = cb; wa = 3'd1; wd = 4'h5;
      if (k == 1) begin
        #1;
        checks++; if (d1 !== 4'hF || d2 !== 4'h9) begin failures++;
          $display("FAIL sweep_reads r7=%h r1=%h required f 9", d1, d2); end
      end
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = 3'(i); a2 = 3'(i); #1;
      checks++; if (d1 !== 4'h0 || b1 !== 1'b0 || b2 !== 1'b0) begin failures++;
        $display("FAIL clear_result reg=%0d data=%h busy=%b required 0 0", i, d1, b1); end
    end
  endtask

  task automatic test_clear_collision();
    bit seen;
    @(negedge clk);
    idle_inputs(); cr = 1'b1; we = 1'b1; wa = 3'd1; wd = 4'h9;
    @(negedge clk);
    idle_inputs(); a1 = 3'd1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk); #1;
      if (cd === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++;
      $display("FAIL collision_done_timeout seen=0 required 1"); end
    checks++; if (d1 !== 4'h0) begin failures++;
      $display("FAIL collision_r1 data=%h required 0", d1); end
    we = 1'b1; wa = 3'd2; wd = 4'h6;
    @(negedge clk);
    idle_inputs(); a2 = 3'd2; #1;
    checks++; if (d2 !== 4'h6 || cb !== 1'b0) begin failures++;
      $display("FAIL write_in_done_cycle data=%h clear_busy=%b required 6 0", d2, cb); end
  endtask

  task automatic test_random32();
    logic [15:0] m_regs [32];
    bit          m_busy [32];
    bit          m_sweep, m_done;
    int          m_next, run, sweeps;
    logic [15:0] e_d1, e_d2;
    logic        e_b1, e_b2;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    m_sweep = 1'b0; m_done = 1'b0; m_next = 0; run = 0; sweeps = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      w_we = 1'($urandom_range(0, 1)); w_wa = 5'($urandom); w_wd = 16'($urandom);
      w_re = 1'($urandom_range(0, 1)); w_ra = 5'($urandom);
      w_a1 = ($urandom_range(0, 3) == 0) ? w_wa : 5'($urandom);
      w_a2 = ($urandom_range(0, 3) == 0) ? w_wa : 5'($urandom);
      w_cr = (n == 100) || ($urandom_range(0, 59) == 0);
      #1;
      e_d1 = m_regs[w_a1]; e_b1 = m_busy[w_a1];
      if (!m_sweep && w_we && w_wa == w_a1) begin e_d1 = w_wd; e_b1 = 1'b0; end
      if (w_a1 == 5'd0) begin e_d1 = '0; e_b1 = 1'b0; end
      e_d2 = m_regs[w_a2]; e_b2 = m_busy[w_a2];
      if (!m_sweep && w_we && w_wa == w_a2) begin e_d2 = w_wd; e_b2 = 1'b0; end
      if (w_a2 == 5'd0) begin e_d2 = '0; e_b2 = 1'b0; end
      checks++; if (w_d1 !== e_d1 || w_b1 !== e_b1) begin failures++;
        $display("FAIL rand_port1 n=%0d addr=%0d data=%h busy=%b required %h %b",
                 n, w_a1, w_d1, w_b1, e_d1, e_b1); end
      checks++; if (w_d2 !== e_d2 || w_b2 !== e_b2) begin failures++;
        $display("FAIL rand_port2 n=%0d addr=%0d data=%h busy=%b required %h %b",
                 n, w_a2, w_d2, w_b2, e_d2, e_b2); end
      checks++; if (w_cb !== m_sweep || w_cd !== m_done) begin failures++;
        $display("FAIL rand_clear n=%0d clear_busy=%b clear_done=%b required %b %b",
                 n, w_cb, w_cd, m_sweep, m_done); end
      if (w_cb === 1'b1) run++;
      else if (run != 0) begin
        checks++; if (run != 31) begin failures++;
          $display("FAIL rand_clear_len cycles=%0d required 31", run); end
        run = 0; sweeps++;
      end
      // Advance the model across the coming edge
      if (!m_sweep) begin
        m_done = 1'b0;
        if (w_cr) begin
          m_sweep = 1'b1; m_next = 1;
          for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
          if (w_we && w_wa != 5'd0) begin m_regs[w_wa] = w_wd; m_busy[w_wa] = 1'b0; end
          if (w_re && w_ra != 5'd0) m_busy[w_ra] = 1'b1;
        end
      end else begin
        m_regs[m_next] = '0;
        m_next++;
        m_done = (m_next == 32);
        if (m_done) m_sweep = 1'b0;
      end
    end
    checks++; if (sweeps == 0) begin failures++;
      $display("FAIL rand_sweeps_seen count=%0d required >0", sweeps); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_scoreboard();
    test_bulk_clear();
    test_clear_collision();
    test_random32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
